// File: rtl/gate_filt_pkg.sv
// Shared types and helpers for the gate output filter.
// Used by gate_out_filter and gate_sync.
package gate_filt_pkg;

  typedef enum logic {STABLE, PENDING} gfilt_state_t;

  function automatic int fcnt_w(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gate_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Async active-high reset clears the whole chain to 0.
module gate_sync
  import gate_filt_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/gate_out_filter.sv
// Sync + debounce of the nand gate output, with edge pulses and count.
// Optional X check on din: define GATE_OUT_FILTER_XCHK_EN.
module gate_out_filter
  import gate_filt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic             din,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             busy
`ifdef GATE_OUT_FILTER_XCHK_EN
  ,
  output logic             xerr
`endif
);

  localparam int FW = fcnt_w(FILT_CYCLES);

  gfilt_state_t   state_q, state_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic           dout_d, rise_d, fall_d;
  logic [CNT_W-1:0] cnt_d;
  logic           ds, ds_eff, flip;

  gate_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (ds)
  );

`ifdef GATE_OUT_FILTER_XCHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 xerr <= 1'b0;
    else if ($isunknown(din)) xerr <= 1'b1;
  end

  // Once X has been seen, freeze the filter on its current level.
  assign ds_eff = xerr ? dout : ds;
`else
  assign ds_eff = ds;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= STABLE;
      fcnt_q   <= '0;
      dout     <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      dout     <= dout_d;
      rise     <= rise_d;
      fall     <= fall_d;
      edge_cnt <= cnt_d;
    end
  end

  assign busy = (state_q == PENDING);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flip    = 1'b0;
    if (!en) begin
      state_d = STABLE;
      fcnt_d  = '0;
    end else begin
      unique case (state_q)
        STABLE: begin
          if (ds_eff != dout) begin
            if (FILT_CYCLES == 1) begin
              flip = 1'b1;
            end else begin
              state_d = PENDING;
              fcnt_d  = FW'(1);
            end
          end
        end
        PENDING: begin
          if (ds_eff == dout) begin
            state_d = STABLE;
            fcnt_d  = '0;
          end else if (fcnt_q == FW'(FILT_CYCLES - 1)) begin
            flip    = 1'b1;
            state_d = STABLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d  = fcnt_q + FW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    dout_d = dout ^ flip;
    rise_d = flip & ~dout;
    fall_d = flip & dout;
    cnt_d  = edge_cnt;
    if (flip && edge_cnt != {CNT_W{1'b1}})
      cnt_d = edge_cnt + CNT_W'(1);
    if (clr_cnt)
      cnt_d = '0;
  end

endmodule

// File: tb/tb_gate_out_filter.sv
// Randomised bench for gate_out_filter against a run-length model.
// Directed phases cover glitch, step, saturation, en drop and async reset.
module tb_gate_out_filter;

  localparam int S  = 2;
  localparam int F  = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, clr_cnt, din;
  logic          dout, rise, fall, busy;
  logic [CW-1:0] edge_cnt;
`ifdef GATE_OUT_FILTER_XCHK_EN
  logic          xerr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: din history, level, length of current disagreeing run.
  logic m_sync [S];
  logic m_dout, m_rise, m_fall, m_busy;
  int   m_run, m_cnt;

  gate_out_filter #(
    .SYNC_STAGES (S),
    .FILT_CYCLES (F),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr_cnt  (clr_cnt),
    .din      (din),
    .dout     (dout),
    .rise     (rise),
    .fall     (fall),
    .edge_cnt (edge_cnt),
    .busy     (busy)
`ifdef GATE_OUT_FILTER_XCHK_EN
    ,
    .xerr     (xerr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
    m_dout = 0; m_rise = 0; m_fall = 0; m_busy = 0;
    m_run = 0; m_cnt = 0;
  endtask

  function automatic bit will_flip();
    return en && (m_sync[S-1] != m_dout) && (m_run == F - 1);
  endfunction

  task automatic model_edge();
    logic ds;
    if (rst) begin
      model_reset();
      return;
    end
    ds = m_sync[S-1];
    m_rise = 0;
    m_fall = 0;
    if (en && ds != m_dout) m_run++;
    else                    m_run = 0;
    if (m_run == F) begin
      m_dout = ds;
      m_rise = ds;
      m_fall = !ds;
      m_run  = 0;
      if (m_cnt < CMAX) m_cnt++;
    end
    if (clr_cnt) m_cnt = 0;
    m_busy = (m_run != 0);
    for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = din;
  endtask

  task automatic compare();
    check("dout", dout, m_dout);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("edge_cnt", edge_cnt, m_cnt);
    check("busy", busy, m_busy);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic hold(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int k, seen_rise;
    rst = 1; en = 1; clr_cnt = 0; din = 0;
    model_reset();
    hold(2);
    rst = 0;

    // Idle after reset
    hold(20);

    // Glitch of 3 samples never reaches dout
    din = 1;
    hold(3);
    din = 0;
    hold(15);
    check("glitch_dout", dout, 0);
    check("glitch_cnt", edge_cnt, 0);

    // Clean step, single rise pulse
    din = 1;
    seen_rise = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      seen_rise += rise;
    end
    check("step_dout", dout, 1);
    check("step_rise_cnt", seen_rise, 1);
    check("step_edge_cnt", edge_cnt, 1);

    // Saturation
    for (int t = 0; t < 300; t++) begin
      din = ~din;
      hold(10);
    end
    check("sat_cnt", edge_cnt, CMAX);

    // clr_cnt coincident with a transition
    din = ~din;
    k = 0;
    while (!will_flip() && k < 40) begin
      cycle();
      k++;
    end
    check("clr_window", will_flip(), 1);
    clr_cnt = 1;
    cycle();
    clr_cnt = 0;
    check("clr_edge", rise | fall, 1);
    check("clr_cnt", edge_cnt, 0);

    // en drop mid-qualification
    din = 0;
    hold(20);
    din = 1;
    k = 0;
    while (m_run != 2 && k < 20) begin
      cycle();
      k++;
    end
    check("en_fcnt2", m_run, 2);
    en = 0;
    hold(5);
    check("en_busy", busy, 0);
    check("en_held", dout, 0);
    en = 1;
    k = 0;
    while (dout == 0 && k < 20) begin
      cycle();
      k++;
    end
    check("en_latency", k, F);

    // Async reset mid-qualification with dout=1
    din = 0;
    hold(3);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_dout", dout, 1);
    #2 rst = 1;
    model_reset();
    #1;
    check("arst_dout", dout, 0);
    check("arst_cnt", edge_cnt, 0);
    check("arst_busy", busy, 0);
    cycle();
    rst = 0;
    hold(5);

    // Random runs
    for (int i = 0; i < 400; i++) begin
      din = $urandom_range(0, 1);
      k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) begin
        en      = ($urandom_range(0, 9) != 0);
        clr_cnt = ($urandom_range(0, 49) == 0);
        cycle();
      end
    end
    en = 1;
    clr_cnt = 0;
    hold(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
